// File: rtl/counter_checker.sv
// counter_checker
// ---------------
// Online self-checking monitor for an enabled up-counter. Every rising edge
// it samples the counter's observed reset, enable and count, predicts the
// next count, and reports mismatches, lock state, errors and wrap events.
//
// Parameters:
//   WIDTH      width of the observed count
//   ERR_WIDTH  width of the error counter
//   LOCK_CNT   consecutive matching samples needed to enter TRACK (1..15)
//
// Ports:
//   clock      single clock, rising edge
//   reset      synchronous active-high reset of the checker only
//   cnt_reset  observed reset of the counter under check
//   enable     observed enable of the counter under check
//   count      observed counter output
//   clear      synchronous clear of err_count
//   locked     high while the FSM is in TRACK
//   mismatch   one-cycle pulse per detected mismatch
//   wrap       one-cycle pulse when a tracked count wraps all-ones -> 0
//   expected   predicted value of count at the next sample
//   err_count  mismatches since reset or the last clear
//
// Build option:
//   COUNTER_CHECKER_SAT_EN  when defined, err_count saturates at all-ones;
//                           otherwise it wraps.

module counter_checker #(
    parameter int WIDTH     = 2,
    parameter int ERR_WIDTH = 8,
    parameter int LOCK_CNT  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 cnt_reset,
    input  logic                 enable,
    input  logic [WIDTH-1:0]     count,
    input  logic                 clear,
    output logic                 locked,
    output logic                 mismatch,
    output logic                 wrap,
    output logic [WIDTH-1:0]     expected,
    output logic [ERR_WIDTH-1:0] err_count
);

    typedef enum logic [1:0] {
        SYNC  = 2'd0,
        LOST  = 2'd1,
        TRACK = 2'd2
    } state_t;

    localparam logic [3:0] LOCK_TARGET = 4'(LOCK_CNT);

    state_t               state;
    logic [3:0]           streak;
    logic [3:0]           streak_inc;
    logic [WIDTH-1:0]     pred;
    logic                 match;
    logic                 err_hit;
    logic                 wrap_cond;
    logic [ERR_WIDTH-1:0] err_next;

    // The prediction is always rebuilt from the observed count rather than
    // from the previous prediction, so one bad sample does not poison the
    // following ones and the checker resyncs on its own.
    always_comb begin
        pred       = '0;
        match      = 1'b0;
        err_hit    = 1'b0;
        wrap_cond  = 1'b0;
        streak_inc = streak + 4'd1;
        if (!cnt_reset) begin
            pred = count + WIDTH'(enable);
        end
        // The compare uses the prediction made last edge, so a counter reset
        // that arrives while count is already wrong still counts as an error.
        match     = (count == expected);
        err_hit   = ((state == LOST) || (state == TRACK)) && !match;
        wrap_cond = (count == '1) && enable && !cnt_reset;
    end

    // Next error count: saturating or wrapping depending on the build.
    always_comb begin
        err_next = err_count;
`ifdef COUNTER_CHECKER_SAT_EN
        if (err_count != '1) begin
            err_next = err_count + ERR_WIDTH'(1);
        end
`else
        err_next = err_count + ERR_WIDTH'(1);
`endif
    end

    // Main FSM with registered outputs. locked is written alongside every
    // state change so it always mirrors "state is TRACK" without a decode.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SYNC;
            streak    <= 4'd0;
            expected  <= '0;
            locked    <= 1'b0;
            mismatch  <= 1'b0;
            wrap      <= 1'b0;
            err_count <= '0;
        end else begin
            expected <= pred;
            mismatch <= 1'b0;
            wrap     <= 1'b0;
            case (state)
                SYNC: begin
                    state  <= LOST;
                    streak <= 4'd0;
                    locked <= 1'b0;
                end
                LOST: begin
                    if (match) begin
                        if (streak_inc >= LOCK_TARGET) begin
                            state  <= TRACK;
                            locked <= 1'b1;
                            streak <= 4'd0;
                        end else begin
                            streak <= streak_inc;
                        end
                    end else begin
                        streak   <= 4'd0;
                        mismatch <= 1'b1;
                    end
                end
                TRACK: begin
                    if (match) begin
                        wrap <= wrap_cond;
                    end else begin
                        state    <= LOST;
                        streak   <= 4'd0;
                        locked   <= 1'b0;
                        mismatch <= 1'b1;
                    end
                end
                default: begin
                    state  <= SYNC;
                    streak <= 4'd0;
                    locked <= 1'b0;
                end
            endcase
            // clear wins over a simultaneous mismatch; the pulse still fires.
            if (clear) begin
                err_count <= '0;
            end else if (err_hit) begin
                err_count <= err_next;
            end
        end
    end

endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker
// ------------------
// Directed, table-driven bench for counter_checker with WIDTH=2,
// ERR_WIDTH=2, LOCK_CNT=4. Each table row is one clock edge of stimulus plus
// the outputs required one cycle later. A hand-written lock-up sequence
// covers the lock latency with a bounded wait.

module tb_counter_checker;

    logic       clock;
    logic       reset;
    logic       cnt_reset;
    logic       enable;
    logic [1:0] count;
    logic       clear;
    logic       locked;
    logic       mismatch;
    logic       wrap;
    logic [1:0] expected;
    logic [1:0] err_count;

    int checks;
    int failures;

`ifdef COUNTER_CHECKER_SAT_EN
    localparam logic [1:0] ERR4 = 2'd3;
    localparam logic [1:0] ERR5 = 2'd3;
`else
    localparam logic [1:0] ERR4 = 2'd0;
    localparam logic [1:0] ERR5 = 2'd1;
`endif

    typedef struct packed {
        logic       rst;
        logic       cr;
        logic       en;
        logic [1:0] cnt;
        logic       clr;
        logic       e_locked;
        logic       e_mm;
        logic       e_wrap;
        logic [1:0] e_exp;
        logic [1:0] e_err;
    } vec_t;

    vec_t vectors[$];

    counter_checker #(
        .WIDTH     (2),
        .ERR_WIDTH (2),
        .LOCK_CNT  (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .cnt_reset (cnt_reset),
        .enable    (enable),
        .count     (count),
        .clear     (clear),
        .locked    (locked),
        .mismatch  (mismatch),
        .wrap      (wrap),
        .expected  (expected),
        .err_count (err_count)
    );

    // 10-unit clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Drive one edge worth of inputs, then settle 1 unit past the edge so
    // the registered outputs are sampled away from the active edge.
    task automatic applyStimulus(input logic rst, input logic cr, input logic en,
                                 input logic [1:0] cnt, input logic clr);
        reset     = rst;
        cnt_reset = cr;
        enable    = en;
        count     = cnt;
        clear     = clr;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input int step,
                               input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s step %0d: got %0d, want %0d", name, step, act, req);
        end
    endtask

    task automatic checkAll(input int step, input vec_t v);
        checkOutput("locked",    step, 8'(locked),    8'(v.e_locked));
        checkOutput("mismatch",  step, 8'(mismatch),  8'(v.e_mm));
        checkOutput("wrap",      step, 8'(wrap),      8'(v.e_wrap));
        checkOutput("expected",  step, 8'(expected),  8'(v.e_exp));
        checkOutput("err_count", step, 8'(err_count), 8'(v.e_err));
    endtask

    initial begin
        int samples;
        int mm_seen;
        checks   = 0;
        failures = 0;
        reset     = 1'b1;
        cnt_reset = 1'b0;
        enable    = 1'b0;
        count     = 2'd0;
        clear     = 1'b0;

        // Fields: rst cr en cnt clr | locked mm wrap expected err
        // Reset state.
        vectors.push_back('{1'b1, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
        vectors.push_back('{1'b1, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
        // Lock-up with a correct counter: SYNC sample, then four matches.
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0});
        // Wrap in TRACK, then one-cycle check.
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0});
        // count=3 with enable=0: no wrap, holds 3; then wrap with enable.
        vectors.push_back('{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd0});
        // Error injection with expected=1, count=2.
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, 2'd1});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 2'd1});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd2, 2'd1});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd3, 2'd1});
        // Counter reset on a matching count=2.
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 2'd0, 2'd1});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd1});
        vectors.push_back('{1'b0, 1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 2'd1});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd1, 2'd1});
        // cnt_reset with a wrong count is still a mismatch.
        vectors.push_back('{1'b0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd2});
        // Clear collides with a mismatch: clear wins, pulse still fires.
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b1, 1'b0, 2'd3, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
        // Plain clear on a matching sample.
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd1});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0});
        // Five mismatches into a 2-bit error counter.
        vectors.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 2'd1});
        vectors.push_back('{1'b0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd1, 2'd2});
        vectors.push_back('{1'b0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 2'd2, 2'd3});
        vectors.push_back('{1'b0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 2'd3, ERR4});
        vectors.push_back('{1'b0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, ERR5});
        // Reset in the middle of a mismatch burst, then restart.
        vectors.push_back('{1'b1, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0, 1'b0, 2'd3, 2'd0});
        vectors.push_back('{1'b0, 1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0});

        for (int i = 0; i < vectors.size(); i++) begin
            applyStimulus(vectors[i].rst, vectors[i].cr, vectors[i].en,
                          vectors[i].cnt, vectors[i].clr);
            checkAll(i, vectors[i]);
        end

        // Lock latency from reset release with a bounded wait: a correct
        // counter must need exactly 1 + LOCK_CNT samples and never mismatch.
        applyStimulus(1'b1, 1'b0, 1'b0, 2'd0, 1'b0);
        samples = 0;
        mm_seen = 0;
        while (!locked && samples < 12) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 2'(samples), 1'b0);
            samples++;
            if (mismatch) mm_seen++;
        end
        checkOutput("lock_locked",   100, 8'(locked),    8'd1);
        checkOutput("lock_samples",  100, 8'(samples),   8'd5);
        checkOutput("lock_mismatch", 100, 8'(mm_seen),   8'd0);
        checkOutput("lock_err",      100, 8'(err_count), 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
